// File: rtl/alu_seq_ctrl.sv
// Button-driven ALU sequencer: load A, load B, load op code, execute, hold the result.
// Optional button debounce is enabled by defining ALU_CTRL_DEBOUNCE_EN.

module alu #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] i_dato_a,
    input  logic [NB_DATA-1:0] i_dato_b,
    input  logic [NB_OP-1:0]   i_operation,
    output logic [NB_DATA-1:0] o_result
);
    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);

    always_comb begin
        o_result = '0;
        case (i_operation)
            OP_ADD:  o_result = i_dato_a + i_dato_b;
            OP_SUB:  o_result = i_dato_a - i_dato_b;
            OP_AND:  o_result = i_dato_a & i_dato_b;
            OP_OR:   o_result = i_dato_a | i_dato_b;
            OP_XOR:  o_result = i_dato_a ^ i_dato_b;
            OP_NOR:  o_result = ~(i_dato_a | i_dato_b);
            default: o_result = '0;
        endcase
    end
endmodule

module alu_btn_pulse #(
    parameter int DEB_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);
    logic       sync1;
    logic       sync2;
    logic       lvl;
    logic       prev;
    logic       arm;
    logic [1:0] rdy;

    // arm only after the synchronizer has flushed and seen the button low,
    // so a button held across reset release never fires
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            arm   <= 1'b0;
            rdy   <= 2'b00;
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
            prev  <= lvl;
            rdy   <= {rdy[0], 1'b1};
            if (rdy[1] && !sync2)
                arm <= 1'b1;
        end
    end

`ifdef ALU_CTRL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             deb;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (sync2 != deb) begin
            if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign lvl = deb;
`else
    assign lvl = sync2;
`endif

    assign o_pulse = lvl && !prev && arm;

    if (DEB_CYCLES < 1) begin : g_deb_chk
        $error("DEB_CYCLES must be at least 1");
    end
endmodule

module alu_seq_ctrl #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP      = 6,
    parameter int DEB_CYCLES = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_sw,
    input  logic               i_btn_a,
    input  logic               i_btn_b,
    input  logic               i_btn_op,
    input  logic               i_btn_clr,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_done,
    output logic               o_err,
    output logic [2:0]         o_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HAVE_A = 3'd1,
        HAVE_B = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t             state;
    logic [NB_DATA-1:0] reg_a;
    logic [NB_DATA-1:0] reg_b;
    logic [NB_OP-1:0]   reg_op;
    logic [NB_DATA-1:0] alu_res;
    logic               a_p;
    logic               b_p;
    logic               op_p;
    logic               clr_p;

    function automatic logic is_supported(input logic [NB_OP-1:0] op);
        case (op)
            NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
            NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b100111):
                is_supported = 1'b1;
            default:
                is_supported = 1'b0;
        endcase
    endfunction

    alu_btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_pulse_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_a), .o_pulse(a_p));
    alu_btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_pulse_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_b), .o_pulse(b_p));
    alu_btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_pulse_op (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_op), .o_pulse(op_p));
    alu_btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_pulse_clr (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_clr), .o_pulse(clr_p));

    alu #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
        .i_dato_a    (reg_a),
        .i_dato_b    (reg_b),
        .i_operation (reg_op),
        .o_result    (alu_res)
    );

    // clr outranks every load; operand registers and o_result survive it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            reg_a    <= '0;
            reg_b    <= '0;
            reg_op   <= '0;
            o_result <= '0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else if (clr_p) begin
            state  <= IDLE;
            o_done <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_p) begin
                        reg_a <= i_sw;
                        state <= HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (b_p) begin
                        reg_b <= i_sw;
                        state <= HAVE_B;
                    end else if (a_p) begin
                        reg_a <= i_sw;
                    end
                end
                HAVE_B: begin
                    if (op_p) begin
                        reg_op <= i_sw[NB_OP-1:0];
                        if (is_supported(i_sw[NB_OP-1:0])) begin
                            state <= EXEC;
                        end else begin
                            state <= ERR;
                            o_err <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    o_result <= alu_res;
                    o_done   <= 1'b1;
                    state    <= DONE;
                end
                DONE, ERR: begin
                    if (a_p) begin
                        reg_a  <= i_sw;
                        o_done <= 1'b0;
                        o_err  <= 1'b0;
                        state  <= HAVE_A;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_state = state;
endmodule
